// File: rtl/clk_phy_rst_seq.sv
// Clock/PHY bring-up sequencer: DCM reset, lock qualification, PHY reset and settle, core release.
// Optional WAIT_LOCK timeout is built only when CLK_SEQ_LOCK_TIMEOUT_EN is defined.
module clk_phy_rst_seq #(
    parameter int unsigned CNT_WIDTH           = 24,
    parameter int unsigned DCM_RST_CYCLES      = 8,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned PHY_RST_CYCLES      = 1000000,
    parameter int unsigned PHY_WAIT_CYCLES     = 500000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dcm_locked,
    input  logic       clkfx_stopped,
    input  logic       restart_req,
    output logic       dcm_rst,
    output logic       phy_reset_n,
    output logic       core_rst,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] retry_count,
    output logic       lock_timeout
);

    typedef enum logic [2:0] {
        S_DCM_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_PHY_RST   = 3'd2,
        S_PHY_WAIT  = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // A zero cycle count behaves as one cycle.
    function automatic logic [CNT_WIDTH-1:0] ld(input int unsigned c);
        return (c == 0) ? CNT_WIDTH'(1) : CNT_WIDTH'(c);
    endfunction

    localparam logic [CNT_WIDTH-1:0] LD_DCM    = ld(DCM_RST_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LD_STABLE = ld(LOCK_STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LD_PHYRST = ld(PHY_RST_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LD_PHYWT  = ld(PHY_WAIT_CYCLES);

    if (((DCM_RST_CYCLES | LOCK_STABLE_CYCLES | PHY_RST_CYCLES | PHY_WAIT_CYCLES |
          LOCK_TIMEOUT_CYCLES) >> CNT_WIDTH) != 0) begin : g_cnt_width_check
        $error("CNT_WIDTH cannot hold every cycle count");
    end

    logic                 r_locked_meta, r_locked_s;
    logic                 r_stopped_meta, r_stopped_s;
    state_t               r_state, w_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                 w_cnt_one, w_lost, w_restart, w_retry_inc;
    logic                 r_dcm_rst, r_phy_reset_n, r_core_rst, r_ready;
    logic [7:0]           r_retry;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_locked_meta  <= 1'b0;
            r_locked_s     <= 1'b0;
            r_stopped_meta <= 1'b0;
            r_stopped_s    <= 1'b0;
        end else begin
            r_locked_meta  <= dcm_locked;
            r_locked_s     <= r_locked_meta;
            r_stopped_meta <= clkfx_stopped;
            r_stopped_s    <= r_stopped_meta;
        end
    end

    assign w_lost    = ~r_locked_s | r_stopped_s;
    assign w_restart = w_lost | restart_req;
    assign w_cnt_one = (r_cnt == CNT_WIDTH'(1));

`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] LD_TO = ld(LOCK_TIMEOUT_CYCLES);
    logic [CNT_WIDTH-1:0] r_to_cnt;
    logic                 w_to_hit;
    logic                 r_lock_to;

    // Timer sits at its load value outside WAIT_LOCK, so entry needs no explicit load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= LD_TO;
            r_lock_to <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_WAIT_LOCK) ? r_to_cnt - CNT_WIDTH'(1) : LD_TO;
            if (w_to_hit)
                r_lock_to <= 1'b1;
        end
    end
    assign lock_timeout = r_lock_to;
`else
    assign lock_timeout = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt - CNT_WIDTH'(1);
        w_retry_inc = 1'b0;
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
        w_to_hit    = 1'b0;
`endif
        case (r_state)
            S_DCM_RST: begin
                if (w_cnt_one) begin
                    w_next     = S_WAIT_LOCK;
                    w_cnt_next = LD_STABLE;
                end
            end
            S_WAIT_LOCK: begin
                if (restart_req) begin
                    w_next      = S_DCM_RST;
                    w_cnt_next  = LD_DCM;
                    w_retry_inc = 1'b1;
                end else if (r_locked_s && w_cnt_one) begin
                    w_next     = S_PHY_RST;
                    w_cnt_next = LD_PHYRST;
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
                end else if (r_to_cnt == CNT_WIDTH'(1)) begin
                    w_next      = S_DCM_RST;
                    w_cnt_next  = LD_DCM;
                    w_retry_inc = 1'b1;
                    w_to_hit    = 1'b1;
`endif
                end else if (!r_locked_s) begin
                    w_cnt_next = LD_STABLE;
                end
            end
            S_PHY_RST: begin
                if (w_restart) begin
                    w_next      = S_DCM_RST;
                    w_cnt_next  = LD_DCM;
                    w_retry_inc = 1'b1;
                end else if (w_cnt_one) begin
                    w_next     = S_PHY_WAIT;
                    w_cnt_next = LD_PHYWT;
                end
            end
            S_PHY_WAIT: begin
                if (w_restart) begin
                    w_next      = S_DCM_RST;
                    w_cnt_next  = LD_DCM;
                    w_retry_inc = 1'b1;
                end else if (w_cnt_one) begin
                    w_next     = S_RUN;
                    w_cnt_next = r_cnt;
                end
            end
            S_RUN: begin
                w_cnt_next = r_cnt;
                if (w_restart) begin
                    w_next      = S_DCM_RST;
                    w_cnt_next  = LD_DCM;
                    w_retry_inc = 1'b1;
                end
            end
            default: begin
                w_next     = S_DCM_RST;
                w_cnt_next = LD_DCM;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_DCM_RST;
            r_cnt         <= LD_DCM;
            r_dcm_rst     <= 1'b1;
            r_phy_reset_n <= 1'b0;
            r_core_rst    <= 1'b1;
            r_ready       <= 1'b0;
            r_retry       <= '0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_dcm_rst     <= (w_next == S_DCM_RST);
            r_phy_reset_n <= (w_next == S_PHY_WAIT) || (w_next == S_RUN);
            r_core_rst    <= (w_next != S_RUN);
            r_ready       <= (w_next == S_RUN);
            if (w_retry_inc && (r_retry != 8'hFF))
                r_retry <= r_retry + 8'd1;
        end
    end

    assign state       = r_state;
    assign dcm_rst     = r_dcm_rst;
    assign phy_reset_n = r_phy_reset_n;
    assign core_rst    = r_core_rst;
    assign ready       = r_ready;
    assign retry_count = r_retry;

endmodule

// File: tb/tb_clk_phy_rst_seq.sv
// Directed bench for clk_phy_rst_seq with short cycle counts; timeout checks follow CLK_SEQ_LOCK_TIMEOUT_EN.
module tb_clk_phy_rst_seq;

    logic       clk = 1'b0;
    logic       reset_n, dcm_locked, clkfx_stopped, restart_req;
    logic       dcm_rst, phy_reset_n, core_rst, ready, lock_timeout;
    logic [2:0] state;
    logic [7:0] retry_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    always #5 clk = ~clk;

    clk_phy_rst_seq #(
        .CNT_WIDTH          (8),
        .DCM_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .PHY_RST_CYCLES     (16),
        .PHY_WAIT_CYCLES    (8),
        .LOCK_TIMEOUT_CYCLES(64)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dcm_locked   (dcm_locked),
        .clkfx_stopped(clkfx_stopped),
        .restart_req  (restart_req),
        .dcm_rst      (dcm_rst),
        .phy_reset_n  (phy_reset_n),
        .core_rst     (core_rst),
        .ready        (ready),
        .state        (state),
        .retry_count  (retry_count),
        .lock_timeout (lock_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Negedges until state matches; returns max if it never does.
    task automatic run_until(input logic [2:0] s, input int max, output int cnt);
        cnt = 0;
        while (state !== s && cnt < max) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic check_reset_vals(input string tag, input logic [7:0] exp_retry);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_dcm_rst"}, 32'(dcm_rst), 1);
        check({tag, "_phy_reset_n"}, 32'(phy_reset_n), 0);
        check({tag, "_core_rst"}, 32'(core_rst), 1);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_retry"}, 32'(retry_count), 32'(exp_retry));
    endtask

    task automatic full_bringup(input string tag, input int first_wait);
        run_until(3'd1, 50, n);  check({tag, "_to_wait_lock"}, n, 32'(first_wait));
        check({tag, "_dcm_rst_low"}, 32'(dcm_rst), 0);
        run_until(3'd2, 50, n);  check({tag, "_to_phy_rst"}, n, 8);
        check({tag, "_phy_still_rst"}, 32'(phy_reset_n), 0);
        run_until(3'd3, 50, n);  check({tag, "_to_phy_wait"}, n, 16);
        check({tag, "_phy_released"}, 32'(phy_reset_n), 1);
        check({tag, "_core_held"}, 32'(core_rst), 1);
        run_until(3'd4, 50, n);  check({tag, "_to_run"}, n, 8);
        check({tag, "_ready"}, 32'(ready), 1);
        check({tag, "_core_rel"}, 32'(core_rst), 0);
    endtask

    initial begin
        reset_n = 1'b0; dcm_locked = 1'b1; clkfx_stopped = 1'b0; restart_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst", 8'd0);
        check("rst_lock_to", 32'(lock_timeout), 0);

        // 1: clean bring-up, 4 + 8 + 16 + 8 cycles
        reset_n = 1'b1;
        full_bringup("t1", 4);
        check("t1_retry", 32'(retry_count), 0);

        // 3: lock lost in RUN -> 2 sync cycles then restart edge
        dcm_locked = 1'b0;
        run_until(3'd0, 20, n);
        check("t3_restart_lat", n, 3);
        check_reset_vals("t3", 8'd1);
        dcm_locked = 1'b1;
        full_bringup("t3_again", 4);

        // 4a: restart_req in RUN, then a req pulse during DCM_RST must not reload the counter
        restart_req = 1'b1;
        @(negedge clk);
        restart_req = 1'b0;
        check_reset_vals("t4_req", 8'd2);
        @(negedge clk);
        restart_req = 1'b1;
        @(negedge clk);
        restart_req = 1'b0;
        run_until(3'd1, 20, n);
        check("t4_dcm_req_ignored", n, 2);
        check("t4_dcm_req_retry", 32'(retry_count), 2);
        run_until(3'd2, 50, n);
        run_until(3'd3, 50, n);
        check("t4_in_phy_wait", 32'(state), 3);
        @(negedge clk);
        restart_req = 1'b1; clkfx_stopped = 1'b1;
        @(negedge clk);
        restart_req = 1'b0; clkfx_stopped = 1'b0;
        check_reset_vals("t4_both", 8'd3);
        full_bringup("t4_again", 4);

        // 4b: lost and restart_req coincide at the FSM -> a single increment
        clkfx_stopped = 1'b1;
        @(negedge clk);
        @(negedge clk);
        restart_req = 1'b1;
        @(negedge clk);
        restart_req = 1'b0; clkfx_stopped = 1'b0;
        check_reset_vals("t4b", 8'd4);

        // 2: one-cycle lock glitch in the 5th stable cycle restarts the stable count
        run_until(3'd1, 20, n);
        check("t2_to_wait_lock", n, 4);
        @(negedge clk);
        @(negedge clk);
        dcm_locked = 1'b0;
        @(negedge clk);
        dcm_locked = 1'b1;
        run_until(3'd2, 50, n);
        check("t2_glitch_delay", n, 10);
        check("t2_retry", 32'(retry_count), 4);

        // 6: asynchronous reset mid-PHY_RST
        repeat (5) @(negedge clk);
        check("t6_pre_state", 32'(state), 2);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("t6", 8'd0);

        // 5: lock never arrives
        dcm_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_until(3'd1, 20, n);
        check("t5_to_wait_lock", n, 4);
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
        run_until(3'd0, 200, n);
        check("t5_timeout_len", n, 64);
        check("t5_lock_to", 32'(lock_timeout), 1);
        check("t5_retry1", 32'(retry_count), 1);
        for (int i = 0; i < 254; i++) begin
            run_until(3'd1, 20, n);
            run_until(3'd0, 200, n);
        end
        check("t5_last_len", n, 64);
        check("t5_retry_sat", 32'(retry_count), 255);
        run_until(3'd1, 20, n);
        run_until(3'd0, 200, n);
        check("t5_retry_hold", 32'(retry_count), 255);
        check("t5_lock_to_sticky", 32'(lock_timeout), 1);
`else
        repeat (200) @(negedge clk);
        check("t5_stays_wait", 32'(state), 1);
        check("t5_no_timeout", 32'(lock_timeout), 0);
        check("t5_no_retry", 32'(retry_count), 0);
        restart_req = 1'b1;
        @(negedge clk);
        restart_req = 1'b0;
        check("t5_wl_req_state", 32'(state), 0);
        check("t5_wl_req_retry", 32'(retry_count), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
